// File: rtl/counter_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
// Optional prescaler is enabled with macro COUNTER_PRESCALE_EN.
package counter_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_t;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_t;

    // Width of a phase counter holding 0..p-1; never narrower than 1 bit.
    function automatic int presc_w(input int p);
        return (p <= 1) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Step-tick generator: one tick every PRESCALE enabled cycles.
// Only instantiated when COUNTER_PRESCALE_EN is defined.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = presc_w(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign tick = en && (phase == LAST);

    // Phase advances only while enabled; clear restarts the interval.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Up/down counter with load, enable, modulus and wrap/saturate mode.
// Define COUNTER_PRESCALE_EN to step once every PRESCALE enabled cycles.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MOD_MAX  = (2**WIDTH) - 1,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             count_en,
    input  logic             up_dn,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] q_out,
    output logic             tc_out,
    output logic             wrap_out
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);

    if (WIDTH < 2 || MOD_MAX < 0 || MOD_MAX > (2**WIDTH) - 1 ||
        PRESCALE < 1) begin : g_bad_params
        $error("updown_counter_param: illegal parameters");
    end

    cnt_dir_t  dir;
    cnt_mode_t mode;
    logic      step_tick;

    assign dir  = cnt_dir_t'(up_dn);
    assign mode = cnt_mode_t'(sat_mode);

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (count_en),
        .clr     (load_en),
        .tick    (step_tick)
    );
`else
    assign step_tick = 1'b1;
`endif

    assign tc_out = (dir == CNT_UP) ? (q_out == MAX_V)
                                    : (q_out == '0);

    // Count register: reset > load > step > hold; wrap_out is a 1-cycle pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_out    <= '0;
            wrap_out <= 1'b0;
        end else if (load_en) begin
            q_out    <= (data_in > MAX_V) ? MAX_V : data_in;
            wrap_out <= 1'b0;
        end else if (count_en && step_tick) begin
            wrap_out <= 1'b0;
            if (dir == CNT_UP) begin
                if (q_out >= MAX_V) begin
                    if (mode == CNT_WRAP) begin
                        q_out    <= '0;
                        wrap_out <= 1'b1;
                    end else begin
                        q_out <= MAX_V;
                    end
                end else begin
                    q_out <= q_out + WIDTH'(1);
                end
            end else begin
                if (q_out == '0) begin
                    if (mode == CNT_WRAP) begin
                        q_out    <= MAX_V;
                        wrap_out <= 1'b1;
                    end
                end else begin
                    q_out <= q_out - WIDTH'(1);
                end
            end
        end else begin
            wrap_out <= 1'b0;
        end
    end

endmodule
